latch_mem_burst: RTL and testbench
==================================

// Module: latch_mem_burst
// PURPOSE
//  Parametrised successor to the single-port 64x8 latch memory: DEPTH x DATA_W storage behind a
//  command engine with burst read, burst write and range fill, using an auto-incrementing,
//  wrapping address pointer. Sits between the TT pin adapter (ui/uio/uo) and the storage array.
//  One command in flight; data beats move one per cycle.
// PARAMETERS
//  DATA_W    8          word width in bits
//  ADDR_W    6          address width; DEPTH = 2**ADDR_W words (no non-power-of-two depths)
//  FILL_VAL  '0         word written by OP_FILL (DATA_W bits)
// PORTS
//  clk          in   1       single clock; all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       engine idle; command accepted when cmd_valid && cmd_ready
//  cmd_op       in   2       00 NOP, 01 READ, 10 WRITE, 11 FILL
//  cmd_addr     in   ADDR_W  start address
//  cmd_len      in   ADDR_W  beats minus one (0 => 1 beat, all-ones => DEPTH beats)
//  wdata_valid  in   1       write beat offered
//  wdata_ready  out  1       write beat accepted when wdata_valid && wdata_ready
//  wdata        in   DATA_W  write data
//  rdata_valid  out  1       read beat present on rdata (no backpressure)
//  rdata        out  DATA_W  read data, registered
//  busy         out  1       ~cmd_ready
//  done         out  1       one-cycle pulse the cycle after the last beat of READ/WRITE/FILL
// BEHAVIOUR
//  - Reset: state=IDLE, cmd_ready=1, busy=0, wdata_ready=0, rdata_valid=0, rdata=0, done=0,
//    ptr=0, cnt=0. Array contents NOT reset (latch storage); reset mid-command aborts it,
//    words already written stay written, no done pulse.
//  - States IDLE, RD, WR, FL. IDLE: cmd_ready=1. On accept: ptr<=cmd_addr, cnt<=cmd_len,
//    go RD/WR/FL per op; NOP accepted, stays IDLE, no done. cmd_ready=0 outside IDLE.
//  - RD: each cycle read mem[ptr] into rdata, rdata_valid=1 the next cycle; ptr++, cnt--.
//    Latency cmd accept -> first rdata_valid = 2 cycles; beats back-to-back; cnt==0 beat
//    is last -> IDLE. done coincides with the last rdata_valid.
//  - WR: wdata_ready=1; on each accepted beat mem[ptr]<=wdata, ptr++, cnt--; stalls
//    (no pointer change) while wdata_valid=0. Beat with cnt==0 -> IDLE, done next cycle.
//    Written word visible to a READ issued the cycle after done.
//  - FL: writes FILL_VAL to mem[ptr] every cycle, ptr++, cnt--; no data handshake; last
//    beat at cnt==0 -> IDLE, done next cycle.
//  - Pointer arithmetic modulo DEPTH: ptr all-ones + 1 wraps to 0; a DEPTH-beat burst
//    touches every word exactly once. cnt is ADDR_W bits, decremented only on a beat.
//  - wdata_valid outside WR is ignored (wdata_ready=0). cmd_valid while busy is held off,
//    not dropped; caller keeps it asserted.
//  - Single write port, single read port into the array; never both in the same cycle.
// STRUCTURE
//  - latch_mem_pkg: op_e {OP_NOP,OP_READ,OP_WRITE,OP_FILL}, state_e {S_IDLE,S_RD,S_WR,S_FL}.
//  - Sub-module latch_mem_array #(DATA_W,ADDR_W): storage, we/waddr/wdata write port,
//    combinational raddr->rdata read port; rdata register lives in latch_mem_burst.
//  - latch_mem_burst: FSM, ptr/cnt counters, handshake outputs, done pulse.
// TESTING
//  1 Reset then WRITE addr=0x10 len=3 data A0..A3 -> 4 accepts, done 1 cycle after A3;
//    READ addr=0x10 len=3 -> rdata A0,A1,A2,A3 on 4 consecutive cycles, first 2 cycles after accept.
//  2 WRITE addr=0x3E len=3 data 11,22,33,44 -> READ 0x3E len=3 gives 11,22,33,44; READ 0x00
//    len=1 gives 33,44 (wrap-around).
//  3 FILL addr=0 len=0x3F with FILL_VAL=0 after random WRITEs -> full READ returns 64x 00,
//    done exactly 64 cycles after the FILL accept.
//  4 WRITE len=2 with wdata_valid gaps of 3 cycles between beats -> no pointer advance in gaps,
//    readback exact; cmd_valid held during burst -> cmd_ready stays 0 until return to IDLE.
//  5 rst pulsed mid WRITE after 2 of 4 beats -> outputs at reset values next cycle, no done;
//    READ shows first 2 words new, last 2 unchanged.
//  6 NOP accepted -> no done, no rdata_valid; ADDR_W=4,DATA_W=16 build passes tests 1-2 scaled.

Source files
------------

// File: rtl/latch_mem_pkg.sv
// Shared types for the burst-capable latch memory: command opcodes and engine states.
package latch_mem_pkg;

   localparam int unsigned OP_W    = 2;
   localparam int unsigned STATE_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2,
      OP_FILL  = 2'd3
   } op_e;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_FL   = 2'd3
   } state_e;

   // NOP maps back to idle so an accepted NOP leaves the engine free
   function automatic state_e op_to_state(input op_e op);
      state_e st;
      case (op)
         OP_READ:  st = S_RD;
         OP_WRITE: st = S_WR;
         OP_FILL:  st = S_FL;
         default:  st = S_IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/latch_mem_array.sv
// DEPTH x DATA_W storage: one clocked write port, one combinational read port.
module latch_mem_array
   import latch_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   // contents are deliberately not reset
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/latch_mem_burst.sv
// Command engine for burst read / burst write / range fill over latch_mem_array,
// driven by a wrapping auto-increment pointer and a beats-remaining counter.
module latch_mem_burst
   import latch_mem_pkg::*;
#(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       ADDR_W   = 6,
   parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done
);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rdata_valid;
   logic              r_done;

   logic              w_idle;
   logic              w_accept;
   logic              w_beat;
   logic              w_last;
   logic              w_we;
   logic              w_rd;
   logic [DATA_W-1:0] w_arr_wdata;
   logic [DATA_W-1:0] w_arr_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = op_to_state(op_e'(cmd_op));
         default: if (w_last)   w_state_nxt = S_IDLE;
      endcase
   end

   // a beat is one word moved; WR beats wait on the write handshake
   always_comb begin
      w_idle      = 1'b0;
      w_rd        = 1'b0;
      w_we        = 1'b0;
      w_beat      = 1'b0;
      w_arr_wdata = wdata;
      case (r_state)
         S_IDLE: w_idle = 1'b1;
         S_RD: begin
            w_rd   = 1'b1;
            w_beat = 1'b1;
         end
         S_WR: begin
            w_we   = wdata_valid;
            w_beat = wdata_valid;
         end
         S_FL: begin
            w_we        = 1'b1;
            w_beat      = 1'b1;
            w_arr_wdata = FILL_VAL;
         end
         default: ;
      endcase
      w_accept = w_idle & cmd_valid;
      w_last   = w_beat & (r_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr         <= '0;
         r_cnt         <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_rdata_valid <= w_rd;
         r_done        <= w_last;
         if (w_rd) begin
            r_rdata <= w_arr_rdata;
         end
         if (w_accept) begin
            r_ptr <= cmd_addr;
            r_cnt <= cmd_len;
         end else if (w_beat) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            r_cnt <= r_cnt - ADDR_W'(1);
         end
      end
   end

   latch_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_ptr),
      .i_wdata (w_arr_wdata),
      .i_raddr (r_ptr),
      .o_rdata (w_arr_rdata)
   );

   assign cmd_ready   = w_idle;
   assign busy        = ~w_idle;
   assign wdata_ready = (r_state == S_WR);
   assign rdata_valid = r_rdata_valid;
   assign rdata       = r_rdata;
   assign done        = r_done;

endmodule

// File: tb/tb_latch_mem_burst.sv
// Randomised scoreboard bench for latch_mem_burst against an array-based memory model.
module tb_latch_mem_burst;
   import latch_mem_pkg::*;

   localparam int unsigned       DATA_W   = 8;
   localparam int unsigned       ADDR_W   = 6;
   localparam int unsigned       DEPTH    = 2 ** ADDR_W;
   localparam logic [DATA_W-1:0] FILL_VAL = '0;

   logic              clk;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] cmd_len;
   logic              wdata_valid;
   logic              wdata_ready;
   logic [DATA_W-1:0] wdata;
   logic              rdata_valid;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              done;

   latch_mem_burst #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .FILL_VAL (FILL_VAL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata       (wdata),
      .rdata_valid (rdata_valid),
      .rdata       (rdata),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DATA_W-1:0] model_mem [DEPTH];
   logic [DATA_W-1:0] exp_q [$];
   logic [DATA_W-1:0] wq [$];
   logic [DATA_W-1:0] mon_e;
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // monitor: every presented read beat is matched against the scoreboard queue
   always @(negedge clk) begin
      if (rdata_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk1("unexpected_rdata_valid", 1'b1, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            chkw("rdata", 32'(rdata), 32'(mon_e));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk1({tag, "_cmd_ready"},   cmd_ready,   1'b1);
      chk1({tag, "_busy"},        busy,        1'b0);
      chk1({tag, "_wdata_ready"}, wdata_ready, 1'b0);
      chk1({tag, "_rdata_valid"}, rdata_valid, 1'b0);
      chkw({tag, "_rdata"},       32'(rdata),  32'h0);
      chk1({tag, "_done"},        done,        1'b0);
   endtask

   // returns just after the accepting clock edge
   task automatic issue(input op_e op, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l);
      int waited = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_len   = l;
      while (cmd_ready !== 1'b1 && waited < 200) begin
         tick();
         waited++;
      end
      chk1("cmd_ready_before_accept", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l);
      logic [ADDR_W-1:0] idx;
      for (int i = 0; i <= int'(l); i++) begin
         idx = a + ADDR_W'(i);
         exp_q.push_back(model_mem[idx]);
      end
      issue(OP_READ, a, l);
      chk1("rd_first_cycle_no_valid", rdata_valid, 1'b0);
      chk1("rd_busy", busy, 1'b1);
      for (int k = 1; k <= int'(l) + 1; k++) begin
         tick();
         chk1("rd_valid", rdata_valid, 1'b1);
         chk1("rd_done", done, k == int'(l) + 1);
      end
      tick();
      chk1("rd_tail_valid", rdata_valid, 1'b0);
      chk1("rd_tail_done", done, 1'b0);
      chk1("rd_tail_cmd_ready", cmd_ready, 1'b1);
      chkw("rd_queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   // data beats come from wq; gap idle cycles between beats; hold keeps a NOP offered
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l,
                           input int gap, input bit hold);
      logic [ADDR_W-1:0] idx;
      issue(OP_WRITE, a, l);
      if (hold) begin
         cmd_valid = 1'b1;
         cmd_op    = OP_NOP;
      end
      for (int i = 0; i <= int'(l); i++) begin
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               wdata_valid = 1'b0;
               tick();
               chk1("wr_gap_wdata_ready", wdata_ready, 1'b1);
               chk1("wr_gap_cmd_ready", cmd_ready, 1'b0);
               chk1("wr_gap_done", done, 1'b0);
            end
         end
         wdata       = wq.pop_front();
         wdata_valid = 1'b1;
         chk1("wr_wdata_ready", wdata_ready, 1'b1);
         chk1("wr_cmd_ready_held_off", cmd_ready, 1'b0);
         idx = a + ADDR_W'(i);
         model_mem[idx] = wdata;
         tick();
         chk1("wr_done", done, i == int'(l));
      end
      wdata_valid = 1'b0;
      cmd_valid   = 1'b0;
      chk1("wr_back_idle", cmd_ready, 1'b1);
      chk1("wr_ready_dropped", wdata_ready, 1'b0);
      tick();
      chk1("wr_tail_done", done, 1'b0);
   endtask

   task automatic do_fill(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l);
      logic [ADDR_W-1:0] idx;
      for (int i = 0; i <= int'(l); i++) begin
         idx = a + ADDR_W'(i);
         model_mem[idx] = FILL_VAL;
      end
      issue(OP_FILL, a, l);
      chk1("fl_wdata_ready", wdata_ready, 1'b0);
      for (int k = 1; k <= int'(l) + 1; k++) begin
         tick();
         chk1("fl_done", done, k == int'(l) + 1);
      end
      chk1("fl_idle", cmd_ready, 1'b1);
      tick();
      chk1("fl_tail_done", done, 1'b0);
   endtask

   task automatic rand_write(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l, input int gap);
      for (int i = 0; i <= int'(l); i++) wq.push_back(DATA_W'($urandom));
      do_write(a, l, gap, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] rl;
      int                op;
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = OP_NOP;
      cmd_addr    = '0;
      cmd_len     = '0;
      wdata_valid = 1'b0;
      wdata       = '0;
      tick();
      tick();
      check_reset_vals("reset");
      rst = 1'b0;

      // basic burst write then burst read
      wq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      do_write(6'h10, 6'd3, 0, 1'b0);
      do_read(6'h10, 6'd3);

      // wrap-around past the top address
      wq = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_write(6'h3E, 6'd3, 0, 1'b0);
      do_read(6'h3E, 6'd3);
      do_read(6'h00, 6'd1);

      // full-depth fill after random writes
      for (int n = 0; n < 5; n++) rand_write(ADDR_W'($urandom), ADDR_W'($urandom_range(0, 15)), 0);
      do_fill(6'h00, 6'h3F);
      do_read(6'h00, 6'h3F);

      // write with data gaps and a command held off
      for (int i = 0; i < 3; i++) wq.push_back(DATA_W'($urandom));
      do_write(6'h20, 6'd2, 3, 1'b1);
      do_read(6'h20, 6'd2);

      // reset mid-write: first two beats land, the rest are untouched
      wq = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
      do_write(6'h08, 6'd3, 0, 1'b0);
      issue(OP_WRITE, 6'h08, 6'd3);
      for (int i = 0; i < 2; i++) begin
         wdata       = DATA_W'(8'hC0 + i);
         wdata_valid = 1'b1;
         model_mem[ADDR_W'(8 + i)] = wdata;
         tick();
      end
      wdata_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("mid_reset");
      tick();
      chk1("mid_reset_no_done", done, 1'b0);
      do_read(6'h08, 6'd3);

      // NOP is accepted and produces nothing
      issue(OP_NOP, 6'h05, 6'd7);
      for (int k = 0; k < 3; k++) begin
         chk1("nop_cmd_ready", cmd_ready, 1'b1);
         chk1("nop_done", done, 1'b0);
         chk1("nop_rdata_valid", rdata_valid, 1'b0);
         tick();
      end

      // randomised mix of operations
      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(1, 3));
         ra = ADDR_W'($urandom);
         rl = ($urandom_range(0, 7) == 0) ? ADDR_W'(DEPTH - 1) : ADDR_W'($urandom_range(0, 12));
         case (op)
            1:       do_read(ra, rl);
            2:       rand_write(ra, rl, int'($urandom_range(0, 2)));
            default: do_fill(ra, rl);
         endcase
      end
      do_read(6'h00, 6'h3F);

      chkw("final_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
